// File: rtl/text_layer_pipe.sv
// -----------------------------------------------------------------------------
// text_layer_pipe
//
// Text-mode pixel pipeline. Turns the scan position into a text RAM address.
// It forwards the returned character code and the cell's pixel row/column to
// the 8x8 character generator. It then blends the generator's 3-bit alpha
// between the cell's foreground and background palette colours, giving one
// RGB444 pixel per clock. Fixed latency is 4 clocks, with no stalls.
//
// Edge timeline for a pixel sampled at edge E0:
//   E0  text RAM address, pixel row/column, active and in_area registered
//   E1  text RAM registers its data; the delay line advances
//   E2  char/fg/bg captured from RAM; row/column driven to the char generator
//   E3  char generator registers alpha; fg/bg/in_area/active delayed
//   E4  blended colour and active flag registered on o_color/o_active
//
// Ports:
//   i_clk         pixel clock, rising edge
//   i_rst         synchronous, active-high reset
//   i_scan_x/y    current scan position (pixels)
//   i_active      scan position is inside active video
//   o_text_addr   text RAM read address (holds outside the text area)
//   i_text_data   text RAM word {bg[15:12], fg[11:8], char[7:0]}, 1-cycle latency
//   o_char        character code to the character generator
//   o_row/column  pixel row/column within the 8x8 cell
//   i_alpha       character generator coverage, 1-cycle latency
//   i_pal_we      palette write strobe
//   i_pal_index   palette entry to write
//   i_pal_data    RGB444 value to write
//   o_color       blended RGB444 pixel
//   o_active      o_color belongs to an active pixel
// -----------------------------------------------------------------------------
module text_layer_pipe #(
  parameter int COLS   = 80,
  parameter int ROWS   = 60,
  parameter int ADDR_W = 13
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [9:0]        i_scan_x,
  input  logic [9:0]        i_scan_y,
  input  logic              i_active,
  output logic [ADDR_W-1:0] o_text_addr,
  input  logic [15:0]       i_text_data,
  output logic [7:0]        o_char,
  output logic [2:0]        o_row,
  output logic [2:0]        o_column,
  input  logic [2:0]        i_alpha,
  input  logic              i_pal_we,
  input  logic [3:0]        i_pal_index,
  input  logic [11:0]       i_pal_data,
  output logic [11:0]       o_color,
  output logic              o_active
);

  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);

  // Per-pixel bookkeeping carried alongside the RAM read.
  typedef struct packed {
    logic       active;
    logic       in_area;
    logic [2:0] row;
    logic [2:0] col;
  } pos_t;

  // ---------------------------------------------------------------------------
  // Stage 0 combinational: cell coordinates and address
  // ---------------------------------------------------------------------------
  logic [6:0]        cell_x;
  logic [6:0]        cell_y;
  logic              in_area;
  logic [ADDR_W-1:0] cell_addr;

  assign cell_x    = i_scan_x[9:3];
  assign cell_y    = i_scan_y[9:3];
  assign in_area   = (int'(cell_x) < COLS) && (int'(cell_y) < ROWS);
  // Modulo-2**ADDR_W arithmetic gives the truncation for free.
  assign cell_addr = ADDR_W'(cell_y) * COLS_A + ADDR_W'(cell_x);

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  pos_t       s0;           // after E0
  pos_t       s1;           // after E1
  logic [3:0] s2_fg;        // after E2
  logic [3:0] s2_bg;
  logic       s2_active;
  logic       s2_in_area;
  logic [3:0] s3_fg;        // after E3
  logic [3:0] s3_bg;
  logic       s3_active;
  logic       s3_in_area;

  logic [11:0] palette [16];
  logic [11:0] pixel_color;

  // NOTE: sequential state is written with <= so every register samples the
  // pre-edge value of the others; that is what makes the delay line shift
  // by exactly one stage per clock instead of collapsing.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_text_addr <= '0;
      s0          <= '0;
      s1          <= '0;
      o_char      <= '0;
      o_row       <= '0;
      o_column    <= '0;
      s2_fg       <= '0;
      s2_bg       <= '0;
      s2_active   <= 1'b0;
      s2_in_area  <= 1'b0;
      s3_fg       <= '0;
      s3_bg       <= '0;
      s3_active   <= 1'b0;
      s3_in_area  <= 1'b0;
      o_color     <= '0;
      o_active    <= 1'b0;
    end else begin
      // E0: address only moves inside the text area to avoid RAM toggling.
      if (in_area) begin
        o_text_addr <= cell_addr;
      end
      s0.active  <= i_active;
      s0.in_area <= in_area;
      s0.row     <= i_scan_y[2:0];
      s0.col     <= i_scan_x[2:0];

      // E1: RAM is busy; just advance the delay line.
      s1 <= s0;

      // E2: capture the RAM word; blank cells become char 0 with palette[0].
      if (s1.active && s1.in_area) begin
        o_char <= i_text_data[7:0];
        s2_fg  <= i_text_data[11:8];
        s2_bg  <= i_text_data[15:12];
      end else begin
        o_char <= 8'h00;
        s2_fg  <= 4'd0;
        s2_bg  <= 4'd0;
      end
      o_row      <= s1.row;
      o_column   <= s1.col;
      s2_active  <= s1.active;
      s2_in_area <= s1.in_area;

      // E3: wait for the character generator's alpha.
      s3_fg      <= s2_fg;
      s3_bg      <= s2_bg;
      s3_active  <= s2_active;
      s3_in_area <= s2_in_area;

      // E4: publish the pixel.
      o_color  <= pixel_color;
      o_active <= s3_active;
    end
  end

  // ---------------------------------------------------------------------------
  // Palette: 16 RGB444 registers, grayscale ramp after reset
  // ---------------------------------------------------------------------------
  // NOTE: the palette is a small register file, not a RAM, so it can and must
  // be reset; a reset value also wins over a write arriving on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 16; i++) begin
        palette[i] <= {4'(i), 4'(i), 4'(i)};
      end
    end else if (i_pal_we) begin
      palette[i_pal_index] <= i_pal_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Blend
  // ---------------------------------------------------------------------------
  // One 4-bit channel: (f*w + b*(8-w)) >> 3. Peak is 15*8 = 120, so 7 bits.
  function automatic logic [3:0] blend_ch(input logic [3:0] f,
                                          input logic [3:0] b,
                                          input logic [3:0] w);
    logic [6:0] acc;
    acc = 7'(f) * 7'(w) + 7'(b) * 7'(4'd8 - w);
    return acc[6:3];
  endfunction

  logic [3:0]  weight;
  logic [11:0] fg_rgb;
  logic [11:0] bg_rgb;

  // NOTE: every signal written in this block gets a default first, so no
  // path through the if/else can leave it unassigned and infer a latch.
  always_comb begin
    pixel_color = 12'h000;
    // Alpha 7 means full foreground; remap it so the weights span 0..8.
    weight      = (i_alpha == 3'd7) ? 4'd8 : {1'b0, i_alpha};
    fg_rgb      = palette[s3_fg];
    bg_rgb      = palette[s3_bg];
    if (s3_active) begin
      if (!s3_in_area) begin
        pixel_color = palette[0];
      end else begin
        pixel_color = {blend_ch(fg_rgb[11:8], bg_rgb[11:8], weight),
                       blend_ch(fg_rgb[7:4],  bg_rgb[7:4],  weight),
                       blend_ch(fg_rgb[3:0],  bg_rgb[3:0],  weight)};
      end
    end
  end

endmodule

// File: tb/tb_text_layer_pipe.sv
// -----------------------------------------------------------------------------
// tb_text_layer_pipe
//
// Directed bench for text_layer_pipe. A behavioural text RAM (1-cycle read)
// and a character generator model (1-cycle, alpha = char[2:0]+row+col mod 8)
// close the loop around the DUT. Table vectors cover single pixels; the
// hand-written sequences cover palette timing, reset and a full scan line.
// -----------------------------------------------------------------------------
module tb_text_layer_pipe;

  localparam int COLS   = 80;
  localparam int ROWS   = 60;
  localparam int ADDR_W = 13;

  logic              clk;
  logic              i_rst;
  logic [9:0]        i_scan_x;
  logic [9:0]        i_scan_y;
  logic              i_active;
  logic [ADDR_W-1:0] o_text_addr;
  logic [15:0]       i_text_data;
  logic [7:0]        o_char;
  logic [2:0]        o_row;
  logic [2:0]        o_column;
  logic [2:0]        i_alpha;
  logic              i_pal_we;
  logic [3:0]        i_pal_index;
  logic [11:0]       i_pal_data;
  logic [11:0]       o_color;
  logic              o_active;

  text_layer_pipe #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_scan_x    (i_scan_x),
    .i_scan_y    (i_scan_y),
    .i_active    (i_active),
    .o_text_addr (o_text_addr),
    .i_text_data (i_text_data),
    .o_char      (o_char),
    .o_row       (o_row),
    .o_column    (o_column),
    .i_alpha     (i_alpha),
    .i_pal_we    (i_pal_we),
    .i_pal_index (i_pal_index),
    .i_pal_data  (i_pal_data),
    .o_color     (o_color),
    .o_active    (o_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Text RAM model
  logic [15:0] mem [8192];
  logic [15:0] ram_q;
  always @(posedge clk) ram_q <= mem[o_text_addr];
  assign i_text_data = ram_q;

  // Character generator model
  function automatic logic [2:0] cg_alpha(input logic [7:0] c,
                                          input logic [2:0] r,
                                          input logic [2:0] k);
    return c[2:0] + r + k;
  endfunction

  logic [2:0] alpha_q;
  always @(posedge clk) alpha_q <= cg_alpha(o_char, o_row, o_column);
  assign i_alpha = alpha_q;

  // Reference blend written channel by channel with plain integers.
  function automatic logic [11:0] ref_blend(input logic [11:0] f,
                                            input logic [11:0] b,
                                            input logic [2:0]  a);
    int w;
    int fc;
    int bc;
    logic [11:0] res;
    w   = (a == 3'd7) ? 8 : int'(a);
    res = '0;
    for (int c = 0; c < 3; c++) begin
      fc = int'((f >> (4 * c)) & 12'h00F);
      bc = int'((b >> (4 * c)) & 12'h00F);
      res[4*c +: 4] = 4'((fc * w + bc * (8 - w)) / 8);
    end
    return res;
  endfunction

  function automatic logic [11:0] default_pal(input logic [3:0] idx);
    return {idx, idx, idx};
  endfunction

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          x;
    int          y;
    logic        act;
    logic [15:0] ram;
    logic [12:0] exp_addr;
    logic [7:0]  exp_char;
    logic [2:0]  exp_row;
    logic [2:0]  exp_col;
    logic [11:0] exp_color;
    logic        exp_act;
  } vec_t;

  vec_t vecs [10];

  logic [11:0] sweep_exp [640];

  initial begin
    // x, y, act, ram, addr, char, row, col, color, active
    vecs[0] = '{6,   0,   1'b1, 16'hF041, 13'd0,    8'h41, 3'd0, 3'd6, 12'h000, 1'b1};
    vecs[1] = '{7,   0,   1'b1, 16'hF041, 13'd0,    8'h41, 3'd0, 3'd7, 12'hFFF, 1'b1};
    vecs[2] = '{17,  9,   1'b1, 16'hF041, 13'd82,   8'h41, 3'd1, 3'd1, 12'h999, 1'b1};
    vecs[3] = '{640, 9,   1'b1, 16'hF041, 13'd82,   8'h00, 3'd1, 3'd0, 12'h000, 1'b1};
    vecs[4] = '{8,   0,   1'b1, 16'h3C0A, 13'd1,    8'h0A, 3'd0, 3'd0, 12'h555, 1'b1};
    vecs[5] = '{639, 479, 1'b1, 16'h4F07, 13'd4799, 8'h07, 3'd7, 3'd7, 12'hAAA, 1'b1};
    vecs[6] = '{8,   480, 1'b1, 16'h4F07, 13'd4799, 8'h00, 3'd0, 3'd0, 12'h000, 1'b1};
    vecs[7] = '{29,  21,  1'b0, 16'h5A42, 13'd163,  8'h00, 3'd5, 3'd5, 12'h000, 1'b0};
    vecs[8] = '{9,   9,   1'b1, 16'h1234, 13'd81,   8'h34, 3'd1, 3'd1, 12'h111, 1'b1};
    vecs[9] = '{631, 7,   1'b1, 16'h0F00, 13'd78,   8'h00, 3'd7, 3'd7, 12'hBBB, 1'b1};

    for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;

    i_rst       = 1'b1;
    i_scan_x    = '0;
    i_scan_y    = '0;
    i_active    = 1'b0;
    i_pal_we    = 1'b0;
    i_pal_index = '0;
    i_pal_data  = '0;
    step();
    step();
    i_rst = 1'b0;

    check("reset_color",  o_color,     12'h000);
    check("reset_active", o_active,    1'b0);
    check("reset_addr",   o_text_addr, 13'd0);
    check("reset_char",   o_char,      8'h00);
    check("reset_row",    o_row,       3'd0);
    check("reset_col",    o_column,    3'd0);

    // ---------------- table vectors: one isolated pixel each ----------------
    for (int v = 0; v < 10; v++) begin
      mem[vecs[v].exp_addr] = vecs[v].ram;
      i_scan_x = 10'(vecs[v].x);
      i_scan_y = 10'(vecs[v].y);
      i_active = vecs[v].act;
      step();                                   // E0
      check($sformatf("v%0d_addr", v), o_text_addr, vecs[v].exp_addr);
      i_active = 1'b0;
      step();                                   // E1
      step();                                   // E2
      check($sformatf("v%0d_char", v), o_char,   vecs[v].exp_char);
      check($sformatf("v%0d_row", v),  o_row,    vecs[v].exp_row);
      check($sformatf("v%0d_col", v),  o_column, vecs[v].exp_col);
      step();                                   // E3
      check($sformatf("v%0d_early_active", v), o_active, 1'b0);
      step();                                   // E4
      check($sformatf("v%0d_color", v),  o_color,  vecs[v].exp_color);
      check($sformatf("v%0d_active", v), o_active, vecs[v].exp_act);
    end

    // ---------------- palette write on the E4 edge, then after it -----------
    mem[0]   = 16'h0441;                        // fg 4, bg 0, alpha 7 at x=6
    i_scan_x = 10'd6;
    i_scan_y = 10'd0;
    i_active = 1'b1;
    step();
    i_active = 1'b0;
    step();
    step();
    step();
    i_pal_we    = 1'b1;
    i_pal_index = 4'd4;
    i_pal_data  = 12'hF00;
    step();                                     // E4 and write on same edge
    i_pal_we = 1'b0;
    check("pal_same_edge", o_color, 12'h444);

    i_active = 1'b1;
    step();
    i_active = 1'b0;
    repeat (4) step();
    check("pal_after_write", o_color, 12'hF00);

    // ---------------- out-of-area colour comes from palette[0] --------------
    i_pal_we    = 1'b1;
    i_pal_index = 4'd0;
    i_pal_data  = 12'h123;
    step();
    i_pal_we = 1'b0;
    i_scan_x = 10'd640;
    i_active = 1'b1;
    step();
    i_active = 1'b0;
    repeat (4) step();
    check("oob_color",  o_color,  12'h123);
    check("oob_active", o_active, 1'b1);
    step();                                     // next pixel was inactive
    check("inactive_color",  o_color,  12'h000);
    check("inactive_active", o_active, 1'b0);

    // ---------------- reset in the middle of a stream -----------------------
    mem[1]   = 16'h3C0A;
    i_scan_y = 10'd0;
    i_active = 1'b1;
    for (int i = 0; i < 10; i++) begin
      i_scan_x = 10'(i);
      step();
    end
    i_rst       = 1'b1;
    i_scan_x    = 10'd10;
    i_pal_we    = 1'b1;                         // reset must win
    i_pal_index = 4'd4;
    i_pal_data  = 12'hABC;
    step();
    check("rst_color",  o_color,     12'h000);
    check("rst_active", o_active,    1'b0);
    check("rst_addr",   o_text_addr, 13'd0);
    check("rst_char",   o_char,      8'h00);
    check("rst_row",    o_row,       3'd0);
    check("rst_col",    o_column,    3'd0);
    i_rst    = 1'b0;
    i_pal_we = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      i_scan_x = 10'(10 + k);
      step();
      if (k <= 4) check($sformatf("rst_flush_active_%0d", k), o_active, 1'b0);
      else        check("rst_first_active", o_active, 1'b1);
    end
    // First post-reset pixel is x=11: cell 1, col 3, alpha 5, fg C, bg 3.
    check("rst_first_color", o_color, 12'h888);
    i_active = 1'b0;
    repeat (4) step();

    i_scan_x = 10'd6;                           // fg 4, alpha 7
    i_active = 1'b1;
    step();
    i_active = 1'b0;
    repeat (4) step();
    check("rst_pal4_default", o_color, 12'h444);

    i_scan_x = 10'd640;
    i_active = 1'b1;
    step();
    i_active = 1'b0;
    repeat (4) step();
    check("rst_pal0_default", o_color, 12'h000);
    check("rst_pal0_active",  o_active, 1'b1);

    // ---------------- continuous line x = 0..639 at y = 0 -------------------
    for (int c = 0; c < COLS; c++) mem[c] = 16'($urandom);
    for (int x = 0; x < 640; x++) begin
      logic [15:0] w;
      w = mem[x / 8];
      sweep_exp[x] = ref_blend(default_pal(w[11:8]), default_pal(w[15:12]),
                               cg_alpha(w[7:0], 3'd0, 3'(x)));
    end
    i_scan_y = 10'd0;
    for (int k = 0; k < 644; k++) begin
      i_active = (k < 640);
      i_scan_x = (k < 640) ? 10'(k) : 10'd0;
      step();
      if (k >= 4) begin
        check($sformatf("sweep_color_x%0d", k - 4), o_color, sweep_exp[k-4]);
        check($sformatf("sweep_active_x%0d", k - 4), o_active, 1'b1);
      end
    end
    i_active = 1'b0;
    step();
    check("sweep_end_active", o_active, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
